// File: rtl/ser_pkg.sv
// Shared types and legal parameter ranges for the parallel-in/serial-out serializer.
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } ser_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;
   localparam int GAP_MIN   = 0;
   localparam int GAP_MAX   = 7;
   localparam int GAP_CNT_W = 3;

   // Gap counter reload value; zero when no gap is configured.
   function automatic logic [GAP_CNT_W-1:0] gap_load(input int gap);
      return (gap > 0) ? GAP_CNT_W'(gap - 1) : '0;
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register that queues the next word while the current one shifts.
module ser_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             pop,
   input  logic             bypass,
   output logic             hold_full,
   output logic [WIDTH-1:0] hold_data
);

   logic push;

   // A bypassed word goes straight to the shifter and must not also be captured here.
   assign push = din_valid && !hold_full && !bypass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (pop) begin
         hold_full <= 1'b0;
      end else if (push) begin
         hold_full <= 1'b1;
         hold_data <= din;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word input, MSB-first serial output
// with a shift-enable qualifier, one-word holding register and configurable idle gap.
module piso_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_en,
   output logic             word_done,
   output logic             busy
);

   localparam int                   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]        BIT_LOAD = CW'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LD   = gap_load(GAP);

   ser_state_t             state, state_nxt;
   logic [WIDTH-1:0]       sreg, sreg_nxt;
   logic [CW-1:0]          bcnt, bcnt_nxt;
   logic [GAP_CNT_W-1:0]   gcnt, gcnt_nxt;
   logic                   hold_full;
   logic [WIDTH-1:0]       hold_data;
   logic                   accept;
   logic                   pop;
   logic                   bypass;
   logic                   reload;

   assign din_ready = !hold_full;
   assign accept    = din_valid && din_ready;

   ser_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .pop       (pop),
      .bypass    (bypass),
      .hold_full (hold_full),
      .hold_data (hold_data)
   );

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      bcnt_nxt  = bcnt;
      gcnt_nxt  = gcnt;
      pop       = 1'b0;
      bypass    = 1'b0;
      reload    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               bypass    = 1'b1;
               sreg_nxt  = din;
               bcnt_nxt  = BIT_LOAD;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
            if (bcnt != '0) begin
               bcnt_nxt = bcnt - CW'(1);
            end else if (GAP > 0) begin
               state_nxt = ST_GAP;
               gcnt_nxt  = GAP_LD;
            end else begin
               reload = 1'b1;
            end
         end
         ST_GAP: begin
            if (gcnt != '0) begin
               gcnt_nxt = gcnt - GAP_CNT_W'(1);
            end else begin
               reload = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // End of a word or gap: a queued word wins over a newly offered one.
      if (reload) begin
         if (hold_full) begin
            pop       = 1'b1;
            sreg_nxt  = hold_data;
            bcnt_nxt  = BIT_LOAD;
            state_nxt = ST_SHIFT;
         end else if (accept) begin
            bypass    = 1'b1;
            sreg_nxt  = din;
            bcnt_nxt  = BIT_LOAD;
            state_nxt = ST_SHIFT;
         end else begin
            state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sreg  <= '0;
         bcnt  <= '0;
         gcnt  <= '0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         bcnt  <= bcnt_nxt;
         gcnt  <= gcnt_nxt;
      end
   end

   assign sout_en   = (state == ST_SHIFT);
   assign sout      = sout_en && sreg[WIDTH-1];
   assign word_done = sout_en && (bcnt == '0);
   assign busy      = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four instances (GAP=0..3) checked every cycle against a
// timeline model of word start times, plus a SIPO-style collector per instance.
module tb_piso_serializer;

   localparam int W    = 4;
   localparam int NI   = 4;
   localparam int MAXW = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [W-1:0] din       [NI];
   logic         din_valid [NI];
   logic         din_ready [NI];
   logic         sout      [NI];
   logic         sout_en   [NI];
   logic         word_done [NI];
   logic         busy      [NI];

   genvar g;
   generate
      for (g = 0; g < NI; g++) begin : g_dut
         piso_serializer #(
            .WIDTH (W),
            .GAP   (g)
         ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (din[g]),
            .din_valid (din_valid[g]),
            .din_ready (din_ready[g]),
            .sout      (sout[g]),
            .sout_en   (sout_en[g]),
            .word_done (word_done[g]),
            .busy      (busy[g])
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;
   int per    = 0;

   // Model: each accepted word has an accept edge k and a start period s.
   int           m_k   [NI][MAXW];
   int           m_s   [NI][MAXW];
   logic [W-1:0] m_d   [NI][MAXW];
   int           m_n   [NI];
   int           m_cmp [NI];
   logic         rdy_exp [NI];

   logic [W-1:0] sq  [NI][$];
   logic [W-1:0] got [NI][$];
   logic [W-1:0] col [NI];
   int           run_cur, run_max, bits0;
   bit           rnd_mode = 1'b0;

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s inst%0d period%0d observed=%0h expected=%0h", tag, i, per, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_n[i]     = 0;
         m_cmp[i]   = 0;
         col[i]     = '0;
         rdy_exp[i] = 1'b1;
         got[i].delete();
         sq[i].delete();
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         logic e_rdy, e_busy, e_so, e_en, e_dn;
         int   n, k, s, idx;
         e_rdy = 1'b1; e_busy = 1'b0; e_so = 1'b0; e_en = 1'b0; e_dn = 1'b0;
         n = m_n[i];
         if (n > 0) begin
            k = m_k[i][n-1];
            s = m_s[i][n-1];
            if (k <= per && per < s) e_rdy = 1'b0;
            if (k <= per && per <= s + W + i - 1) e_busy = 1'b1;
         end
         for (int j = (n > 3 ? n - 3 : 0); j < n; j++) begin
            s = m_s[i][j];
            if (s <= per && per <= s + W - 1) begin
               idx  = W - 1 - (per - s);
               e_en = 1'b1;
               e_so = m_d[i][j][idx];
               e_dn = (per == s + W - 1);
            end
         end
         chk("din_ready", i, din_ready[i], e_rdy);
         chk("busy",      i, busy[i],      e_busy);
         chk("sout_en",   i, sout_en[i],   e_en);
         chk("sout",      i, sout[i],      e_so);
         chk("word_done", i, word_done[i], e_dn);
         rdy_exp[i] = e_rdy;
         if (sout_en[i] === 1'b1) col[i] = {col[i][W-2:0], sout[i]};
         if (word_done[i] === 1'b1) got[i].push_back(col[i]);
      end
      if (sout_en[0] === 1'b1) begin
         run_cur++;
         bits0++;
         if (run_cur > run_max) run_max = run_cur;
      end else begin
         run_cur = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      per++;
      for (int i = 0; i < NI; i++) begin
         if (rst_n && din_valid[i] && rdy_exp[i] && m_n[i] < MAXW) begin
            int s, n;
            n = m_n[i];
            s = per;
            if (n > 0 && m_s[i][n-1] + W + i > s) s = m_s[i][n-1] + W + i;
            m_k[i][n] = per;
            m_s[i][n] = s;
            m_d[i][n] = din[i];
            m_n[i]    = n + 1;
            if (sq[i].size() > 0) void'(sq[i].pop_front());
         end
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         din_valid[i] = (sq[i].size() > 0) && (!rnd_mode || ($urandom_range(0, 1) == 1));
         din[i]       = (sq[i].size() > 0) ? sq[i][0] : W'($urandom);
      end
      @(negedge clk);
      check_all();
   endtask

   function automatic logic pending();
      logic p;
      p = 1'b0;
      for (int i = 0; i < NI; i++) begin
         if (sq[i].size() > 0) p = 1'b1;
         if (m_n[i] > 0 && m_s[i][m_n[i]-1] + W + i - 1 >= per) p = 1'b1;
      end
      return p;
   endfunction

   task automatic run_until_idle(input int limit);
      int n;
      n = 0;
      while (pending() && n < limit) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 0, pending(), 1'b0);
      repeat (2) cycle();
   endtask

   task automatic check_words(input int i);
      int ne;
      ne = m_n[i] - m_cmp[i];
      chk("word_count", i, got[i].size(), ne);
      for (int j = 0; j < ne && j < got[i].size(); j++)
         chk("word_data", i, got[i][j], m_d[i][m_cmp[i]+j]);
      m_cmp[i] = m_n[i];
      got[i].delete();
   endtask

   logic [W-1:0] el [3];
   logic [W-1:0] w0, w1;

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         din[i]       = '0;
         din_valid[i] = 1'b0;
      end
      run_cur = 0; run_max = 0; bits0 = 0;
      model_reset();
      @(negedge clk);
      check_all();
      repeat (3) cycle();
      #2 rst_n = 1'b1;
      repeat (2) cycle();

      // Single word, GAP=1
      sq[1].push_back(4'b1011);
      run_until_idle(40);
      chk("single_cnt", 1, got[1].size(), 1);
      if (got[1].size() > 0) chk("single_sipo", 1, got[1][0], 4'b1011);
      check_words(1);

      // Back-to-back with no gap
      run_max = 0;
      el[0] = 4'hA; el[1] = 4'h5; el[2] = 4'hF;
      for (int j = 0; j < 3; j++) sq[0].push_back(el[j]);
      run_until_idle(60);
      chk("b2b_run", 0, run_max, 12);
      chk("b2b_cnt", 0, got[0].size(), 3);
      for (int j = 0; j < 3 && j < got[0].size(); j++) chk("b2b_word", 0, got[0][j], el[j]);
      check_words(0);

      // Gap insertion, GAP=2
      w0 = W'($urandom); w1 = W'($urandom);
      sq[2].push_back(w0); sq[2].push_back(w1);
      run_until_idle(60);
      check_words(2);

      // Backpressure, GAP=3
      el[0] = 4'h1; el[1] = 4'h2; el[2] = 4'h3;
      for (int j = 0; j < 3; j++) sq[3].push_back(el[j]);
      run_until_idle(80);
      chk("bp_cnt", 3, got[3].size(), 3);
      for (int j = 0; j < 3 && j < got[3].size(); j++) chk("bp_word", 3, got[3][j], el[j]);
      check_words(3);

      // Reset mid-word
      bits0 = 0;
      sq[0].push_back(4'hC);
      for (int n = 0; n < 20 && bits0 < 2; n++) cycle();
      chk("rst_setup", 0, bits0, 2);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      repeat (2) cycle();
      #2 rst_n = 1'b1;
      cycle();
      sq[0].push_back(4'h3);
      run_until_idle(40);
      chk("post_rst_cnt", 0, got[0].size(), 1);
      if (got[0].size() > 0) chk("post_rst_word", 0, got[0][0], 4'h3);
      check_words(0);

      // Randomized traffic on all instances
      rnd_mode = 1'b1;
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < 30; j++) sq[i].push_back(W'($urandom));
      run_until_idle(4000);
      rnd_mode = 1'b0;
      for (int i = 0; i < NI; i++) check_words(i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
